// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op codes,
// FSM state encodings and the op-signedness helper.
package mdu_pkg;

  localparam int MDU_OP_W = 3;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   part_s;
  logic [WIDTH-1:0] diff_s;

  assign part_s = {rem_i, dvd_bit_i};
  // When the subtraction is taken the result is below the divisor, so WIDTH bits suffice.
  assign diff_s = part_s[WIDTH-1:0] - divisor_i;
  assign q_o    = (part_s >= {1'b0, divisor_i});
  assign rem_o  = q_o ? diff_s : part_s[WIDTH-1:0];

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit: one bit per cycle on operand magnitudes,
// sign applied when HI/LO are written on the final iteration.
module mdu
  import mdu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    num1,
  input  logic [WIDTH-1:0]    num2,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo,
  output logic                op_invalid
);

  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + ONE_2W;
  endfunction

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] opa_q, opa_d;   // multiplicand (MUL) or dividend/quotient shifter (DIV)
  logic [WIDTH-1:0]   opb_q, opb_d;   // multiplier (MUL) or divisor (DIV)
  logic [2*WIDTH-1:0] acc_q, acc_d;   // product accumulator or partial remainder
  logic               neg_q, neg_d;
  logic               dneg_q, dneg_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, inv_q, inv_d;

  mdu_op_e            op_s;
  logic               a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [2*WIDTH-1:0] prod_s, res_s;
  logic [WIDTH-1:0]   quo_s, step_rem_s;
  logic               step_q_s;

  assign op_s = mdu_op_e'(op);

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (acc_q[WIDTH-1:0]),
    .dvd_bit_i (opa_q[WIDTH-1]),
    .divisor_i (opb_q),
    .rem_o     (step_rem_s),
    .q_o       (step_q_s)
  );

  // Next-state, datapath and result selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    dneg_d  = dneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    inv_d   = 1'b0;

    a_neg_s = op_is_signed(op_s) & num1[WIDTH-1];
    b_neg_s = op_is_signed(op_s) & num2[WIDTH-1];
    a_mag_s = a_neg_s ? neg_w(num1) : num1;
    b_mag_s = b_neg_s ? neg_w(num2) : num2;
    prod_s  = acc_q + (opb_q[0] ? opa_q : {(2*WIDTH){1'b0}});
    res_s   = neg_q ? neg_2w(prod_s) : prod_s;
    quo_s   = {opa_q[WIDTH-2:0], step_q_s};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op_s)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              opa_d   = {{WIDTH{1'b0}}, a_mag_s};
              opb_d   = b_mag_s;
              acc_d   = {(2*WIDTH){1'b0}};
              neg_d   = a_neg_s ^ b_neg_s;
              dneg_d  = a_neg_s;
              cnt_d   = {CNT_W{1'b0}};
              busy_d  = 1'b1;
              state_d = ((op_s == MDU_MULT) || (op_s == MDU_MULTU)) ? ST_MUL : ST_DIV;
            end
            MDU_MTHI: hi_d  = num1;
            MDU_MTLO: lo_d  = num1;
            default:  inv_d = 1'b1;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_d = prod_s;
        opa_d = {opa_q[2*WIDTH-2:0], 1'b0};
        opb_d = {1'b0, opb_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          {hi_d, lo_d} = res_s;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DIV: begin
        acc_d = {{WIDTH{1'b0}}, step_rem_s};
        opa_d = {{WIDTH{1'b0}}, quo_s};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // Divide by zero leaves the dividend magnitude as remainder, so the
          // normal sign fix returns the raw dividend in HI.
          lo_d    = (opb_q == {WIDTH{1'b0}}) ? {WIDTH{1'b1}}
                                             : (neg_q ? neg_w(quo_s) : quo_s);
          hi_d    = dneg_q ? neg_w(step_rem_s) : step_rem_s;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DIV;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      opa_q   <= {(2*WIDTH){1'b0}};
      opb_q   <= {WIDTH{1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
      neg_q   <= 1'b0;
      dneg_q  <= 1'b0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      dneg_q  <= dneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      inv_q   <= inv_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign op_invalid = inv_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a 32-bit and an 8-bit instance share clock and reset.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, start8;
  logic [2:0]  op32, op8;
  logic [31:0] a32, b32, hi32, lo32;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy32, done32, inv32, busy8, done8, inv8;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  mdu #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .num1(a32), .num2(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .op_invalid(inv32)
  );

  mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .num1(a8), .num2(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .op_invalid(inv8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start32 = 1'b1; op32 = o; a32 = a; b32 = b;
    tick();
    start32 = 1'b0;
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1; op8 = o; a8 = a; b8 = b;
    tick();
    start8 = 1'b0;
  endtask

  task automatic wait_done32(output int cyc);
    cyc = 0;
    while (done32 !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start32 = 1'b0; start8 = 1'b0;
    op32 = 3'd0; op8 = 3'd0; a32 = 32'd0; b32 = 32'd0; a8 = 8'd0; b8 = 8'd0;
    tick(); tick();
    reset = 1'b0;
    nchecks++;
    if ({busy32, done32, inv32} !== 3'b000) begin
      nerr++; $display("FAIL reset_flags32: got %b expected 000", {busy32, done32, inv32});
    end
    nchecks++;
    if ({hi32, lo32} !== 64'd0) begin
      nerr++; $display("FAIL reset_hilo32: got %h expected 0", {hi32, lo32});
    end
    nchecks++;
    if ({busy8, done8, inv8, hi8, lo8} !== 19'd0) begin
      nerr++; $display("FAIL reset_8: got %h expected 0", {busy8, done8, inv8, hi8, lo8});
    end
  endtask

  task automatic test_multu();
    int cyc;
    issue32(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    a32 = 32'h1234_5678; b32 = 32'h0000_0002;
    nchecks++;
    if (busy32 !== 1'b1) begin
      nerr++; $display("FAIL multu_busy: got %b expected 1", busy32);
    end
    wait_done32(cyc);
    nchecks++;
    if (cyc != 32) begin
      nerr++; $display("FAIL multu_latency: got %0d expected 32", cyc);
    end
    nchecks++;
    if ({hi32, lo32, busy32} !== {32'hFFFF_FFFE, 32'h0000_0001, 1'b0}) begin
      nerr++; $display("FAIL multu_result: got %h %h busy %b expected fffffffe 00000001 busy 0", hi32, lo32, busy32);
    end
    tick();
    nchecks++;
    if (done32 !== 1'b0) begin
      nerr++; $display("FAIL multu_done_pulse: got %b expected 0", done32);
    end
  endtask

  task automatic test_signed();
    int cyc;
    issue32(3'd0, 32'hFFFF_FFFD, 32'd7);
    repeat (5) tick();
    nchecks++;
    if ({hi32, lo32} !== {32'hFFFF_FFFE, 32'h0000_0001}) begin
      nerr++; $display("FAIL hold_while_busy: got %h %h expected fffffffe 00000001", hi32, lo32);
    end
    wait_done32(cyc);
    nchecks++;
    if ({hi32, lo32} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin
      nerr++; $display("FAIL mult_neg: got %h %h expected ffffffff ffffffeb", hi32, lo32);
    end
    tick();
    issue32(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done32(cyc);
    nchecks++;
    if ({hi32, lo32} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      nerr++; $display("FAIL div_neg: got %h %h expected ffffffff fffffffd", hi32, lo32);
    end
    tick();
    issue32(3'd3, 32'd7, 32'd2);
    wait_done32(cyc);
    nchecks++;
    if ({hi32, lo32} !== {32'd1, 32'd3}) begin
      nerr++; $display("FAIL divu_7_2: got %h %h expected 00000001 00000003", hi32, lo32);
    end
    tick();
  endtask

  task automatic test_boundary();
    int cyc;
    issue32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done32(cyc);
    nchecks++;
    if ({hi32, lo32} !== {32'd0, 32'h8000_0000}) begin
      nerr++; $display("FAIL div_minneg: got %h %h expected 00000000 80000000", hi32, lo32);
    end
    tick();
    issue32(3'd3, 32'd5, 32'd0);
    wait_done32(cyc);
    nchecks++;
    if ({hi32, lo32, cyc} !== {32'd5, 32'hFFFF_FFFF, 32'd32}) begin
      nerr++; $display("FAIL divu_by_zero: got %h %h cyc %0d expected 00000005 ffffffff cyc 32", hi32, lo32, cyc);
    end
    tick();
    issue32(3'd2, 32'hFFFF_FFFB, 32'd0);
    wait_done32(cyc);
    nchecks++;
    if ({hi32, lo32} !== {32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin
      nerr++; $display("FAIL div_neg_by_zero: got %h %h expected fffffffb ffffffff", hi32, lo32);
    end
    tick();
  endtask

  task automatic test_move();
    issue32(3'd4, 32'h0000_1234, 32'd0);
    nchecks++;
    if ({hi32, done32, busy32} !== {32'h0000_1234, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL mthi: got %h done %b busy %b expected 00001234 done 0 busy 0", hi32, done32, busy32);
    end
    issue32(3'd5, 32'h0000_5678, 32'd0);
    nchecks++;
    if ({hi32, lo32, done32} !== {32'h0000_1234, 32'h0000_5678, 1'b0}) begin
      nerr++; $display("FAIL mtlo: got %h %h done %b expected 00001234 00005678 done 0", hi32, lo32, done32);
    end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    issue32(3'd3, 32'd100, 32'd7);
    repeat (4) tick();
    issue32(3'd1, 32'd2, 32'd3);
    issue32(3'd4, 32'hDEAD_BEEF, 32'd0);
    nchecks++;
    if ({hi32, busy32} !== {32'h0000_1234, 1'b1}) begin
      nerr++; $display("FAIL busy_mthi_ignored: got %h busy %b expected 00001234 busy 1", hi32, busy32);
    end
    wait_done32(cyc);
    nchecks++;
    if ({hi32, lo32, cyc} !== {32'd2, 32'd14, 32'd26}) begin
      nerr++; $display("FAIL busy_divu_result: got %h %h cyc %0d expected 00000002 0000000e cyc 26", hi32, lo32, cyc);
    end
    tick();
    nchecks++;
    if (busy32 !== 1'b0) begin
      nerr++; $display("FAIL busy_start_dropped: got busy %b expected 0", busy32);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    issue32(3'd2, 32'd1000, 32'd3);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nchecks++;
    if ({busy32, done32, hi32, lo32} !== 66'd0) begin
      nerr++; $display("FAIL reset_mid: got busy %b done %b %h %h expected all 0", busy32, done32, hi32, lo32);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done32 === 1'b1 || busy32 === 1'b1) pulses++;
    end
    nchecks++;
    if (pulses != 0) begin
      nerr++; $display("FAIL reset_mid_discard: got %0d active cycles expected 0", pulses);
    end
  endtask

  task automatic test_invalid();
    issue32(3'd4, 32'hAAAA_0001, 32'd0);
    issue32(3'd5, 32'h5555_0002, 32'd0);
    issue32(3'd7, 32'h1111_1111, 32'h2222_2222);
    nchecks++;
    if ({inv32, busy32, hi32, lo32} !== {1'b1, 1'b0, 32'hAAAA_0001, 32'h5555_0002}) begin
      nerr++; $display("FAIL invalid_op7: got inv %b busy %b %h %h expected inv 1 busy 0 aaaa0001 55550002", inv32, busy32, hi32, lo32);
    end
    tick();
    nchecks++;
    if (inv32 !== 1'b0) begin
      nerr++; $display("FAIL invalid_pulse: got %b expected 0", inv32);
    end
    issue32(3'd6, 32'h3333_3333, 32'd0);
    nchecks++;
    if ({inv32, hi32, lo32} !== {1'b1, 32'hAAAA_0001, 32'h5555_0002}) begin
      nerr++; $display("FAIL invalid_op6: got inv %b %h %h expected inv 1 aaaa0001 55550002", inv32, hi32, lo32);
    end
    tick();
  endtask

  task automatic test_width8();
    int cyc;
    issue8(3'd0, 8'h80, 8'h80);
    wait_done8(cyc);
    nchecks++;
    if ({hi8, lo8, cyc} !== {8'h40, 8'h00, 32'd8}) begin
      nerr++; $display("FAIL w8_mult: got %h %h cyc %0d expected 40 00 cyc 8", hi8, lo8, cyc);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    issue8(3'd1, 8'h0F, 8'h11);
    wait_done8(cyc);
    nchecks++;
    if ({hi8, lo8, cyc} !== {8'h00, 8'hFF, 32'd8}) begin
      nerr++; $display("FAIL b2b_first: got %h %h cyc %0d expected 00 ff cyc 8", hi8, lo8, cyc);
    end
    issue8(3'd3, 8'd200, 8'd7);
    nchecks++;
    if ({busy8, done8} !== 2'b10) begin
      nerr++; $display("FAIL b2b_accept: got busy %b done %b expected busy 1 done 0", busy8, done8);
    end
    wait_done8(cyc);
    nchecks++;
    if ({hi8, lo8, cyc} !== {8'h04, 8'h1C, 32'd8}) begin
      nerr++; $display("FAIL b2b_second: got %h %h cyc %0d expected 04 1c cyc 8", hi8, lo8, cyc);
    end
    issue8(3'd2, 8'hF9, 8'h02);
    wait_done8(cyc);
    nchecks++;
    if ({hi8, lo8} !== {8'hFF, 8'hFD}) begin
      nerr++; $display("FAIL b2b_third: got %h %h expected ff fd", hi8, lo8);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_multu();
    test_signed();
    test_boundary();
    test_move();
    test_busy_ignore();
    test_reset_mid();
    test_invalid();
    test_width8();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Parametrised multi-cycle multiply/divide unit. It is the sequential companion to the combinational ALU in the datapath.
- Computes signed/unsigned WIDTH x WIDTH products and quotient/remainder pairs iteratively, one bit per cycle, into HI/LO result registers.
- Also supports direct HI/LO writes.
- Sits beside the ALU in EX. The pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width (legal: 8..64, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled on rising edge when busy=0.
- op  in  3  operation, encodings in mdu.h.
- num1  in  WIDTH  operand A / dividend / MTHI-MTLO data.
- num2  in  WIDTH  operand B / divisor.
- busy  out  1  iteration in progress.
- done  out  1  one-cycle pulse: HI/LO just updated by MULT*/DIV*.
- hi  out  WIDTH  HI register: product upper half / remainder.
- lo  out  WIDTH  LO register: product lower half / quotient.
- op_invalid  out  1  one-cycle pulse: start accepted with unknown op.

Behaviour:
- Reset (synchronous, active-high; wins over everything, including mid-operation):
  - busy=0, done=0, op_invalid=0, hi=0, lo=0, counter=0, state=IDLE.
  - An in-flight operation is discarded.
- Ops: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5. Codes 6-7 are invalid.
- States: IDLE, MUL, DIV.
- IDLE, start=1:
  - MULT/MULTU: latch operands and op → MUL, busy=1, counter=0.
  - DIV/DIVU: latch operands and op → DIV, busy=1, counter=0.
  - MTHI: hi<=num1 on the same edge. Stays IDLE, no done pulse.
  - MTLO: lo<=num1 on the same edge. Stays IDLE, no done pulse.
  - Invalid op: op_invalid=1 for one cycle. hi/lo unchanged, stays IDLE.
- start while busy=1: ignored entirely, including MTHI/MTLO. The operation in progress is unaffected.
- Latency:
  - Accept edge E0, then one iteration per edge E1..E_WIDTH. busy is high for exactly WIDTH cycles.
  - On E_WIDTH: hi/lo written, busy<=0, done<=1 for one cycle, → IDLE.
  - A new start is accepted on the edge after busy falls, so back-to-back issue is possible in the done cycle.
- Signed ops: magnitudes are latched at E0 and iterated unsigned. The sign fix is applied when writing at E_WIDTH.
- MUL:
  - Shift-add, 2*WIDTH-bit accumulator.
  - {hi,lo} = full 2*WIDTH-bit product. No truncation, no overflow flag.
- DIV:
  - Restoring division. lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Boundary cases:
  - Divide by zero: full latency still taken. lo = all ones, hi = num1 (the dividend, raw).
  - DIV with most-negative dividend / -1: lo = most-negative value, hi = 0.
  - Operands are held internally; changes on num1/num2 after E0 have no effect.
- hi/lo are readable at all times. While busy they hold the old values, which are not clobbered until E_WIDTH.

Decomposition:
- mdu.h (shared header, alongside alu.h): MDU_* op codes, state encodings, MDU_OP_W=3.
- Sub-module mdu_div_step: combinational single restoring-division step.
  - Inputs: partial remainder, quotient bit source, divisor.
  - Outputs: next remainder, quotient bit.
- The top level holds the FSM, counter, accumulators and sign fix.

Test Plan:
1. WIDTH=32, MULTU 0xFFFFFFFF*0xFFFFFFFF → after 32 busy cycles, done pulse; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT -3*7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1.
3. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 5/0 → lo=0xFFFFFFFF, hi=5, 32-cycle latency.
4. MTHI 0x1234 while idle → hi=0x1234 next edge, no done. Start MULTU 2*3 while busy from a prior DIVU → ignored; prior result correct.
5. Assert reset on cycle 10 of a DIV → next edge: busy=0, hi=lo=0, no done. Op=7 while idle → op_invalid single pulse, hi/lo unchanged.
6. WIDTH=8 instance: MULT 0x80*0x80 → {hi,lo}=0x4000 after 8 cycles. Back-to-back starts issued in the done cycle both complete correctly.
